des_enc: RTL and testbench

DES_ENC -- requirements
Module: des_enc

---
 rtl/des_enc.sv | 172 +++++++++++++++++
 tb/tb_des_enc.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_enc.sv
// Iterative DES encryption core: one Feistel round per clock, 17-cycle block period.
// Optional `busy` status output is enabled by defining DES_ENC_BUSY_EN.
module des_enc (
   input  logic        clk,
   input  logic        rstn,
   input  logic [63:0] plain,
   input  logic        plain_en,
   input  logic [63:0] key,
   output logic [63:0] cipher,
   output logic        cipher_rdy
`ifdef DES_ENC_BUSY_EN
   ,
   output logic        busy
`endif
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Tables hold FIPS bit numbers (1 = MSB), one byte per entry, first entry leftmost.
   localparam logic [511:0] IP_TBL = {
      8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,  8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
      8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,  8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
      8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
      8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,  8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7};

   localparam logic [511:0] FP_TBL = {
      8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32, 8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
      8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30, 8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
      8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28, 8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
      8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26, 8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25};

   localparam logic [383:0] E_TBL = {
      8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,
      8'd8,  8'd9,  8'd10, 8'd11, 8'd12, 8'd13, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
      8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25,
      8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1};

   localparam logic [255:0] P_TBL = {
      8'd16, 8'd7, 8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17, 8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
      8'd2,  8'd8, 8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,  8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25};

   localparam logic [447:0] PC1_TBL = {
      8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
      8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
      8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
      8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4};

   localparam logic [383:0] PC2_TBL = {
      8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
      8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
      8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
      8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32};

   // S1..S8, 64 nibbles each, indexed by {b1,b6,b2..b5} of the 6-bit group.
   localparam logic [2047:0] SBOX = {
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   // Input occupies the n_in LSBs of x; result occupies the n_out LSBs.
   function automatic logic [63:0] permute(input logic [63:0] x, input logic [511:0] tbl,
                                           input int n_in, input int n_out);
      logic [63:0] y;
      logic [7:0]  src;
      y = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < n_out) begin
            src = 8'(tbl >> (8 * (n_out - 1 - i)));
            y   = {y[62:0], 1'(x >> (n_in - int'(src)))};
         end
      end
      return y;
   endfunction

   function automatic logic [31:0] sbox_layer(input logic [47:0] x);
      logic [31:0] y;
      logic [5:0]  six;
      logic [5:0]  idx;
      y = '0;
      for (int b = 0; b < 8; b++) begin
         six = 6'(x >> (42 - 6 * b));
         idx = {six[5], six[0], six[4:1]};
         y   = {y[27:0], 4'(SBOX >> (2044 - 256 * b - 4 * int'(idx)))};
      end
      return y;
   endfunction

   logic [0:0]  state_q, state_d;
   logic [63:0] lr_q, lr_d;
   logic [55:0] cd_q, cd_d;
   logic [3:0]  rnd_q, rnd_d;
   logic [63:0] cipher_q, cipher_d;
   logic        rdy_q, rdy_d;

   logic        one_shift;
   logic [27:0] c_rot, d_rot;
   logic [47:0] subkey;
   logic [47:0] e_r;
   logic [31:0] f_out;
   logic [31:0] r_next;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      lr_d     = lr_q;
      cd_d     = cd_q;
      rnd_d    = rnd_q;
      cipher_d = cipher_q;
      rdy_d    = 1'b0;

      // Rounds 1, 2, 9 and 16 rotate by one; the rest by two.
      one_shift = (rnd_q == 4'd0) || (rnd_q == 4'd1) || (rnd_q == 4'd8) || (rnd_q == 4'd15);
      c_rot  = one_shift ? {cd_q[54:28], cd_q[55]} : {cd_q[53:28], cd_q[55:54]};
      d_rot  = one_shift ? {cd_q[26:0], cd_q[27]}  : {cd_q[25:0], cd_q[27:26]};
      subkey = 48'(permute({8'd0, c_rot, d_rot}, 512'(PC2_TBL), 56, 48));
      e_r    = 48'(permute({32'd0, lr_q[31:0]}, 512'(E_TBL), 32, 48));
      f_out  = 32'(permute({32'd0, sbox_layer(e_r ^ subkey)}, 512'(P_TBL), 32, 32));
      r_next = lr_q[63:32] ^ f_out;

      if (state_q == ST_IDLE) begin
         if (plain_en) begin
            lr_d    = permute(plain, IP_TBL, 64, 64);
            cd_d    = 56'(permute(key, 512'(PC1_TBL), 64, 56));
            rnd_d   = 4'd0;
            state_d = ST_BUSY;
         end
      end else begin
         lr_d  = {lr_q[31:0], r_next};
         cd_d  = {c_rot, d_rot};
         rnd_d = rnd_q + 4'd1;
         if (rnd_q == 4'd15) begin
            // Final swap: preoutput is R16||L16.
            cipher_d = permute({r_next, lr_q[31:0]}, FP_TBL, 64, 64);
            rdy_d    = 1'b1;
            state_d  = ST_IDLE;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         lr_q     <= '0;
         cd_q     <= '0;
         rnd_q    <= '0;
         cipher_q <= '0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lr_q     <= lr_d;
         cd_q     <= cd_d;
         rnd_q    <= rnd_d;
         cipher_q <= cipher_d;
         rdy_q    <= rdy_d;
      end
   end

   assign cipher     = cipher_q;
   assign cipher_rdy = rdy_q;

`ifdef DES_ENC_BUSY_EN
   assign busy = (state_q == ST_BUSY);
`endif

endmodule

// File: tb/tb_des_enc.sv
// Self-checking bench for des_enc: directed known-answer vectors plus random blocks
// compared against a bit-level DES reference model and a cycle-timing scoreboard.
module tb_des_enc;

   logic        clk;
   logic        rstn;
   logic [63:0] plain;
   logic        plain_en;
   logic [63:0] key;
   logic [63:0] cipher;
   logic        cipher_rdy;
`ifdef DES_ENC_BUSY_EN
   logic        busy;
`endif

   des_enc dut (
      .clk        (clk),
      .rstn       (rstn),
      .plain      (plain),
      .plain_en   (plain_en),
      .key        (key),
      .cipher     (cipher),
      .cipher_rdy (cipher_rdy)
`ifdef DES_ENC_BUSY_EN
      ,
      .busy       (busy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
   localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                 19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   localparam int SB [512] = '{
      14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,    0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,    15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
      15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,    3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,    13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
      10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,    13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,    1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
      7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,    13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,    3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
      2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,    14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,    11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
      12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,    10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,    4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
      4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,    13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,    6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
      13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,    1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,    2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

   // Whole-block DES on FIPS-numbered vectors (index 1 = MSB), all 16 rounds at once.
   function automatic logic [63:0] ref_des(input logic [63:0] k, input logic [63:0] pt);
      logic [1:64] kb, pb, ipb, pre, ob;
      logic [1:56] cd;
      logic [1:28] c, d;
      logic [1:48] ks [16];
      logic [1:48] er;
      logic [1:32] l, r, so, fo, t;
      int          row, col;
      kb = k;
      pb = pt;
      for (int i = 1; i <= 56; i++) cd[i] = kb[PC1_T[i-1]];
      c = cd[1:28];
      d = cd[29:56];
      for (int n = 0; n < 16; n++) begin
         for (int s = 0; s < SH_T[n]; s++) begin
            c = {c[2:28], c[1]};
            d = {d[2:28], d[1]};
         end
         cd = {c, d};
         for (int i = 1; i <= 48; i++) ks[n][i] = cd[PC2_T[i-1]];
      end
      for (int i = 1; i <= 64; i++) ipb[i] = pb[IP_T[i-1]];
      l = ipb[1:32];
      r = ipb[33:64];
      for (int n = 0; n < 16; n++) begin
         for (int i = 1; i <= 48; i++) er[i] = r[E_T[i-1]];
         er = er ^ ks[n];
         for (int b = 0; b < 8; b++) begin
            row = 2 * int'(er[6*b+1]) + int'(er[6*b+6]);
            col = 8 * int'(er[6*b+2]) + 4 * int'(er[6*b+3]) + 2 * int'(er[6*b+4]) + int'(er[6*b+5]);
            so[4*b+1 +: 4] = 4'(SB[b*64 + row*16 + col]);
         end
         for (int i = 1; i <= 32; i++) fo[i] = so[P_T[i-1]];
         t = r;
         r = l ^ fo;
         l = t;
      end
      pre = {r, l};
      for (int i = 1; i <= 64; i++) ob[i] = pre[FP_T[i-1]];
      return ob;
   endfunction

   int          checks;
   int          errors;
   int          left;
   int          cyc;
   int          last_pulse;
   logic [63:0] pend;
   logic [63:0] exp_cipher;
   logic        exp_rdy;
   logic [63:0] rk, rp;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // One clock: drive inputs, advance the timing scoreboard, compare outputs after the edge.
   task automatic step(input logic en, input logic [63:0] p, input logic [63:0] k);
      plain_en = en;
      plain    = p;
      key      = k;
      @(posedge clk);
      #1;
      cyc++;
      exp_rdy = 1'b0;
      if (left == 0) begin
         if (en) begin
            pend = ref_des(k, p);
            left = 16;
         end
      end else begin
         left--;
         if (left == 0) begin
            exp_rdy    = 1'b1;
            exp_cipher = pend;
         end
      end
      check("cipher_rdy", {63'd0, cipher_rdy}, {63'd0, exp_rdy});
      check("cipher", cipher, exp_cipher);
`ifdef DES_ENC_BUSY_EN
      check("busy", {63'd0, busy}, {63'd0, left > 0});
`endif
   endtask

   task automatic reset_pulse();
      rstn = 1'b0;
      #1;
      left       = 0;
      exp_cipher = '0;
      check("rst_cipher", cipher, 64'h0);
      check("rst_rdy", {63'd0, cipher_rdy}, 64'h0);
`ifdef DES_ENC_BUSY_EN
      check("rst_busy", {63'd0, busy}, 64'h0);
`endif
      @(posedge clk);
      #1;
      check("rst_hold_cipher", cipher, 64'h0);
      rstn = 1'b1;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      left       = 0;
      cyc        = 0;
      pend       = '0;
      exp_cipher = '0;
      exp_rdy    = 1'b0;
      plain_en   = 1'b0;
      plain      = '0;
      key        = '0;
      rstn       = 1'b1;
      @(posedge clk);
      #1;
      reset_pulse();

      // Classic worked example, 16-cycle latency checked by the scoreboard.
      step(1'b1, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1);
      repeat (16) step(1'b0, '0, '0);
      check("kat_classic", cipher, 64'h85E813540F0AB405);

      step(1'b1, 64'h0, 64'h0);
      repeat (16) step(1'b0, '0, '0);
      check("kat_zero_key", cipher, 64'h8CA64DE9C1B123A7);

      // Parity bits set must not change the result.
      step(1'b1, 64'h0, 64'h0101010101010101);
      repeat (16) step(1'b0, '0, '0);
      check("kat_parity_key", cipher, 64'h8CA64DE9C1B123A7);

      // Inputs scrambled while busy; the captured block must win.
      step(1'b1, 64'hDEADBEEFCAFEF00D, 64'h0F1E2D3C4B5A6978);
      repeat (16) step(1'b1, rand64(), rand64());
      repeat (20) step(1'b0, '0, '0);

      // plain_en toggling every cycle with constant inputs.
      for (int t = 0; t < 60; t++)
         step(t % 2 == 0, 64'h0001020304050607, 64'h133457799BBCDFF1);
      repeat (20) step(1'b0, '0, '0);

      // plain_en held high: back-to-back blocks every 17 cycles.
      last_pulse = -1;
      for (int t = 0; t < 52; t++) begin
         step(1'b1, 64'h0001020304050607, 64'h133457799BBCDFF1);
         if (cipher_rdy) begin
            if (last_pulse >= 0) check("period", 64'(cyc - last_pulse), 64'd17);
            last_pulse = cyc;
         end
      end
      repeat (20) step(1'b0, '0, '0);

      // Abort at round 8, confirm silence, then a clean block straight after release.
      step(1'b1, rand64(), rand64());
      repeat (8) step(1'b0, '0, '0);
      reset_pulse();
      rp = rand64();
      rk = rand64();
      step(1'b1, rp, rk);
      repeat (16) step(1'b0, '0, '0);
      check("after_reset", cipher, ref_des(rk, rp));
      repeat (20) step(1'b0, '0, '0);

      // Random blocks with random idle gaps and random strobes while busy.
      for (int b = 0; b < 12; b++) begin
         step(1'b1, rand64(), rand64());
         repeat (16) step(1'($urandom_range(0, 1)), rand64(), rand64());
         repeat ($urandom_range(0, 3)) step(1'b0, rand64(), rand64());
      end
      repeat (20) step(1'b0, '0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
